// File: rtl/wb_master_pipelined.sv
// Wishbone B4 pipelined master: turns a valid/ready command stream into
// pipelined bus requests and returns in-order responses.
module wb_master_pipelined #(
  parameter int unsigned adr_width       = 16,
  parameter int unsigned dat_width       = 16,
  parameter int unsigned max_outstanding = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [adr_width-1:0] cmd_adr,
  input  logic [dat_width-1:0] cmd_dat,
  output logic                 rsp_valid,
  output logic                 rsp_we,
  output logic [dat_width-1:0] rsp_dat,
  output logic                 err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [adr_width-1:0] wb_adr,
  output logic [dat_width-1:0] wb_dat_o,
  input  logic [dat_width-1:0] wb_dat_i,
  input  logic                 wb_ack,
  input  logic                 wb_stall
);

  localparam int unsigned IW = $clog2(max_outstanding + 1);
  localparam int unsigned PW = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
  localparam logic [IW-1:0] MAX_CNT  = IW'(max_outstanding);
  localparam logic [PW-1:0] LAST_PTR = PW'(max_outstanding - 1);

  logic [IW-1:0]              inflight_q, inflight_d;
  logic [max_outstanding-1:0] tags_q, tags_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic                       wb_cyc_q, wb_cyc_d;
  logic                       wb_stb_q, wb_stb_d;
  logic                       wb_we_q, wb_we_d;
  logic [adr_width-1:0]       wb_adr_q, wb_adr_d;
  logic [dat_width-1:0]       wb_dat_o_q, wb_dat_o_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_we_q, rsp_we_d;
  logic [dat_width-1:0]       rsp_dat_q, rsp_dat_d;
  logic                       err_q, err_d;
  logic                       cmd_ready_c;
  logic                       accept_c;
  logic                       ack_ok_c;
  logic                       pop_tag_c;

  // Ring-pointer increment that wraps at the FIFO depth.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Accept gating: credit limit plus no pending stalled request.
  always_comb begin
    cmd_ready_c = (inflight_q < MAX_CNT) && (!wb_stb_q || !wb_stall);
    accept_c    = cmd_valid && cmd_ready_c;
    ack_ok_c    = wb_ack && (inflight_q != '0);
    pop_tag_c   = tags_q[rd_ptr_q];
  end

  // Next-state for request stage, credit counter, tag FIFO and response stage.
  always_comb begin
    inflight_d  = inflight_q;
    tags_d      = tags_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wb_stb_d    = wb_stb_q;
    wb_we_d     = wb_we_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_o_d  = wb_dat_o_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = 1'b0;
    rsp_dat_d   = '0;
    err_d       = err_q;

    if (accept_c && !ack_ok_c) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!accept_c && ack_ok_c) begin
      inflight_d = inflight_q - IW'(1);
    end

    if (accept_c) begin
      wb_stb_d         = 1'b1;
      wb_we_d          = cmd_we;
      wb_adr_d         = cmd_adr;
      wb_dat_o_d       = cmd_dat;
      tags_d[wr_ptr_q] = cmd_we;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (wb_stb_q && !wb_stall) begin
      wb_stb_d = 1'b0;
    end

    if (ack_ok_c) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      rsp_valid_d = 1'b1;
      rsp_we_d    = pop_tag_c;
      rsp_dat_d   = pop_tag_c ? '0 : wb_dat_i;
    end

    if (wb_ack && (inflight_q == '0)) begin
      err_d = 1'b1;
    end

    wb_cyc_d = (inflight_d != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      tags_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_o_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_dat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      tags_q      <= tags_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_stb_q    <= wb_stb_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_o_q  <= wb_dat_o_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_dat_q   <= rsp_dat_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_c;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;
  assign wb_adr    = wb_adr_q;
  assign wb_dat_o  = wb_dat_o_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_dat   = rsp_dat_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_master_pipelined.sv
// Bench for wb_master_pipelined: Wishbone slave model, transaction-level
// reference model with a per-cycle compare process, and directed scenarios.
module tb_wb_master_pipelined;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [15:0] cmd_dat = '0;
  logic        rsp_valid, rsp_we, err;
  logic [15:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr, wb_dat_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;

  wb_master_pipelined #(.adr_width(16), .dat_width(16), .max_outstanding(MAXO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_dat(rsp_dat), .err(err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  typedef struct { int due; logic [15:0] dat; } ack_t;
  ack_t        ack_q[$];
  logic [15:0] smem [0:255];
  int          cyc_n     = 0;
  int          ack_delay = 0;
  logic        force_ack = 1'b0;

  // Drive ack/data just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      wb_ack = force_ack;
      if (ack_q.size() > 0 && ack_q[0].due <= cyc_n) begin
        wb_ack   = 1'b1;
        wb_dat_i = ack_q[0].dat;
        void'(ack_q.pop_front());
      end
    end
  end

  // Take requests that will be accepted at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wb_cyc && wb_stb && !wb_stall) begin
        if (wb_we) smem[wb_adr[7:0]] = wb_dat_o;
        ack_q.push_back('{cyc_n + 1 + ack_delay, wb_we ? 16'h0 : smem[wb_adr[7:0]]});
      end
    end
  end

  // ---------------- reference model + compare ----------------
  typedef struct { logic we; logic [15:0] dat; } rsp_t;
  rsp_t        exp_q[$];
  logic [15:0] m_mem [0:255];
  logic [15:0] rsp_log [$];
  int          m_inflight = 0;
  int          peak       = 0;
  logic        m_err      = 1'b0;
  logic        m_pend     = 1'b0;
  int          rsp_cnt    = 0;
  logic        burst_chk  = 1'b0;
  int          burst_end  = 0;
  logic        hold_prev  = 1'b0;
  logic        p_we;
  logic [15:0] p_adr, p_dat;

  initial begin
    for (int i = 0; i < 256; i++) begin
      smem[i]  = 16'hA000 + 16'(i);
      m_mem[i] = 16'hA000 + 16'(i);
    end
  end

  always @(negedge clk) begin
    logic exp_ready;
    logic acc;
    logic ackv;
    rsp_t e;
    exp_ready = (m_inflight < MAXO) && !(wb_stb && wb_stall);
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("wb_cyc", wb_cyc, m_inflight != 0);
    chk("err", err, m_err);
    chk("rsp_valid", rsp_valid, m_pend);
    if (m_pend) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_we", rsp_we, e.we);
        chk("rsp_dat", rsp_dat, e.dat);
      end
      rsp_log.push_back(rsp_dat);
      rsp_cnt++;
    end
    if (hold_prev) begin
      chk("stall_stb", wb_stb, 1);
      chk("stall_adr", wb_adr, p_adr);
      chk("stall_we", wb_we, p_we);
      chk("stall_dat", wb_dat_o, p_dat);
    end
    if (burst_chk && rsp_cnt < burst_end) chk("cyc_cont", wb_cyc, 1);

    if (rst) begin
      m_inflight = 0;
      m_err      = 1'b0;
      m_pend     = 1'b0;
      hold_prev  = 1'b0;
      exp_q.delete();
    end else begin
      acc  = cmd_valid && exp_ready;
      ackv = wb_ack && (m_inflight != 0);
      if (wb_ack && m_inflight == 0) m_err = 1'b1;
      m_pend = ackv;
      if (acc) begin
        exp_q.push_back('{cmd_we, cmd_we ? 16'h0 : m_mem[cmd_adr[7:0]]});
        if (cmd_we) m_mem[cmd_adr[7:0]] = cmd_dat;
      end
      m_inflight = m_inflight + (acc ? 1 : 0) - (ackv ? 1 : 0);
      if (m_inflight > peak) peak = m_inflight;
      hold_prev = wb_stb && wb_stall;
      p_we  = wb_we;
      p_adr = wb_adr;
      p_dat = wb_dat_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic we, input logic [15:0] adr, input logic [15:0] dat);
    logic acc;
    int   n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        chk("send_timeout", 0, 1);
        acc = 1'b1;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target || wb_cyc) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 300) begin
        chk("rsp_timeout", rsp_cnt, target);
        break;
      end
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hard stop if anything escapes the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ready", cmd_ready, 1);
    cycles(1);

    // Single write to a zero-wait slave.
    send(1'b1, 16'd1, 16'd101);
    @(negedge clk);
    chk("sw_stb1", wb_stb, 1);
    chk("sw_cyc1", wb_cyc, 1);
    chk("sw_adr", wb_adr, 16'd1);
    chk("sw_dat", wb_dat_o, 16'd101);
    chk("sw_we", wb_we, 1);
    @(negedge clk);
    chk("sw_stb2", wb_stb, 0);
    chk("sw_cyc2", wb_cyc, 1);
    @(negedge clk);
    chk("sw_cyc3", wb_cyc, 0);
    chk("sw_rv", rsp_valid, 1);
    chk("sw_rwe", rsp_we, 1);
    chk("sw_rdat", rsp_dat, 0);
    @(negedge clk);
    chk("sw_rv_once", rsp_valid, 0);
    cycles(1);

    // Burst writes then burst reads, cmd_valid held high.
    burst_end = rsp_cnt + 10;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 16'(11 + i), 16'(211 + i));
      burst_chk = 1'b1;
    end
    wait_rsp(burst_end);
    burst_chk = 1'b0;
    for (int i = 0; i < 10; i++) chk("bw_mem", smem[11 + i], 16'(211 + i));

    base = rsp_cnt;
    burst_end = base + 10;
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 16'(11 + i), 16'h0);
      burst_chk = 1'b1;
    end
    wait_rsp(burst_end);
    burst_chk = 1'b0;
    for (int i = 0; i < 10; i++) chk("br_dat", rsp_log[base + i], 16'(211 + i));
    cycles(2);

    // Stall for 3 cycles on a read of adr 5.
    wb_stall = 1'b1;
    base = rsp_cnt;
    send(1'b0, 16'd5, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_stb", wb_stb, 1);
      chk("st_adr", wb_adr, 16'd5);
      chk("st_ready", cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    wb_stall = 1'b0;
    wait_rsp(base + 1);
    chk("st_rdat", rsp_log[base], 16'hA005);
    cycles(2);

    // Outstanding limit with slow acks.
    ack_delay = 6;
    peak = 0;
    base = rsp_cnt;
    for (int i = 0; i < 8; i++) send(1'b0, 16'(11 + i), 16'h0);
    wait_rsp(base + 8);
    chk("ol_peak", peak, MAXO);
    for (int i = 0; i < 8; i++) chk("ol_dat", rsp_log[base + i], 16'(211 + i));
    ack_delay = 0;
    cycles(2);

    // Spurious ack while idle.
    base = rsp_cnt;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sp_err", err, 1);
    cycles(5);
    @(negedge clk);
    chk("sp_err_sticky", err, 1);
    chk("sp_no_rsp", rsp_cnt, base);
    cycles(1);

    // Reset with two reads outstanding; late acks land during reset.
    ack_delay = 6;
    send(1'b0, 16'd11, 16'h0);
    send(1'b0, 16'd12, 16'h0);
    base = rsp_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mr_cyc", wb_cyc, 0);
    chk("mr_stb", wb_stb, 0);
    chk("mr_we", wb_we, 0);
    chk("mr_adr", wb_adr, 0);
    chk("mr_dato", wb_dat_o, 0);
    chk("mr_rv", rsp_valid, 0);
    chk("mr_rdat", rsp_dat, 0);
    chk("mr_err", err, 0);
    chk("mr_ready", cmd_ready, 1);
    cycles(12);
    rst = 1'b0;
    ack_delay = 0;
    cycles(2);
    @(negedge clk);
    chk("mr_no_late_rsp", rsp_cnt, base);
    chk("mr_err_clear", err, 0);
    cycles(1);
    send(1'b0, 16'd3, 16'h0);
    wait_rsp(base + 1);
    chk("mr_read3", rsp_log[base], 16'hA003);
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
